// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// Widths here are the default configuration; the arbiter itself is parameterized.
package unified_mem_pkg;

  localparam int UM_ADDR_W = 13;
  localparam int UM_DATA_W = 32;
  localparam int UM_BE_W   = UM_DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  typedef struct packed {
    logic [UM_ADDR_W-1:0] addr;
    logic                 we;
    logic [UM_BE_W-1:0]   be;
    logic [UM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, load/store and block-memory port bundle seen by the arbiter.
// slave = arbiter view; master = requesters + memory view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = unified_mem_pkg::UM_ADDR_W,
  parameter int DATA_W = unified_mem_pkg::UM_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [BE_W-1:0]   ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port block-RAM arbiter: load/store priority with a bounded streak so
// fetch cannot starve; read data routed to the owner one cycle after grant.
module unified_mem_arbiter
  import unified_mem_pkg::*;
#(
  parameter int ADDR_W        = UM_ADDR_W,
  parameter int DATA_W        = UM_DATA_W,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  localparam int SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [SW-1:0]     streak;
  owner_e            owner;
  logic [DATA_W-1:0] if_hold, ls_hold;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              streak_full, pick_ls, grant_ls, grant_if;
  logic              if_rvalid, ls_rvalid;
  logic [ADDR_W-1:0] addr_c;

  // Grants are masked while reset is held so nothing reaches the RAM.
  always_comb begin
    streak_full = (streak == STREAK_MAX);
    pick_ls     = bus.ls_req && !(bus.if_req && streak_full);
    grant_ls    = rst && pick_ls;
    grant_if    = rst && bus.if_req && !pick_ls;
    addr_c      = addr_q;
    if (grant_ls)      addr_c = bus.ls_addr;
    else if (grant_if) addr_c = bus.if_addr;
  end

  assign bus.if_gnt    = grant_if;
  assign bus.ls_gnt    = grant_ls;
  assign bus.mem_en    = grant_if || grant_ls;
  assign bus.mem_we    = (grant_ls && bus.ls_we) ? bus.ls_be : '0;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = grant_ls ? bus.ls_wdata : wdata_q;

  assign if_rvalid     = (owner == OWN_IF);
  assign ls_rvalid     = (owner == OWN_LS);
  assign bus.if_rvalid = if_rvalid;
  assign bus.ls_rvalid = ls_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_hold;
  assign bus.ls_rdata  = ls_rvalid ? bus.mem_rdata : ls_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak  <= '0;
      owner   <= OWN_NONE;
      if_hold <= '0;
      ls_hold <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // Streak only matters while fetch is actually waiting.
      if (!bus.if_req || grant_if)
        streak <= '0;
      else if (grant_ls && !streak_full)
        streak <= streak + SW'(1);

      if (grant_ls && !bus.ls_we) owner <= OWN_LS;
      else if (grant_if)          owner <= OWN_IF;
      else                        owner <= OWN_NONE;

      addr_q <= addr_c;
      if (grant_ls) wdata_q <= bus.ls_wdata;

      if (if_rvalid) if_hold <= bus.mem_rdata;
      if (ls_rvalid) ls_hold <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a write-first synchronous RAM model.
module tb_unified_mem_arbiter;
  import unified_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_init = 1'b1;
  int   checks = 0;
  int   errors = 0;

  unified_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_LS_STREAK(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (load_init) begin
      mem[13'h010] <= 32'h0050_0093;
      mem[13'h011] <= 32'hDEAD_BEEF;
      mem[13'h100] <= 32'h1122_3344;
      mem[13'h101] <= 32'h0BAD_F00D;
    end else if (bus.mem_en) begin
      mem[bus.mem_addr] <= merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_we);
      bus.mem_rdata     <= merge(mem[bus.mem_addr], bus.mem_wdata, bus.mem_we);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic ls_drive(input mem_req_t r);
    bus.ls_addr  = r.addr;
    bus.ls_we    = r.we;
    bus.ls_be    = r.be;
    bus.ls_wdata = r.wdata;
  endtask

  logic        alt_if   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [12:0] alt_addr [4] = '{13'h010, 13'h101, 13'h011, 13'h100};
  logic [31:0] alt_data [4] = '{32'h0050_0093, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1122_CCDD};
  logic        pat_if  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0;
    ls_drive('{addr: 13'h0, we: 1'b0, be: 4'h0, wdata: 32'h0});
    bus.mem_rdata = '0;

    // Reset held: requests must not reach the RAM.
    repeat (2) @(posedge clk);
    #1 bus.if_req = 1'b1; bus.ls_req = 1'b1;
    mid();
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_ls_gnt", bus.ls_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    next_cycle();
    bus.if_req = 1'b0; bus.ls_req = 1'b0; rst_n = 1'b1; load_init = 1'b0;
    mid();
    chk("idle_if_gnt", bus.if_gnt, 0);
    chk("idle_ls_gnt", bus.ls_gnt, 0);
    chk("idle_if_rvalid", bus.if_rvalid, 0);
    chk("idle_ls_rvalid", bus.ls_rvalid, 0);
    chk("idle_mem_en", bus.mem_en, 0);
    chk("idle_if_rdata", bus.if_rdata, 0);
    chk("idle_ls_rdata", bus.ls_rdata, 0);

    // Fetch only.
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 13'h010;
    mid();
    chk("if_gnt", bus.if_gnt, 1);
    chk("if_ls_gnt", bus.ls_gnt, 0);
    chk("if_mem_en", bus.mem_en, 1);
    chk("if_mem_addr", bus.mem_addr, 13'h010);
    chk("if_mem_we", bus.mem_we, 0);
    next_cycle();
    bus.if_req = 1'b0;
    mid();
    chk("if_rvalid", bus.if_rvalid, 1);
    chk("if_rdata", bus.if_rdata, 32'h0050_0093);
    chk("if_idle_mem_en", bus.mem_en, 0);
    chk("if_addr_held", bus.mem_addr, 13'h010);
    next_cycle();
    mid();
    chk("if_rvalid_drop", bus.if_rvalid, 0);
    chk("if_rdata_hold", bus.if_rdata, 32'h0050_0093);

    // Partial store, load, zero-enable store, load.
    next_cycle();
    bus.ls_req = 1'b1;
    ls_drive('{addr: 13'h100, we: 1'b1, be: 4'b0011, wdata: 32'hAABB_CCDD});
    mid();
    chk("st_ls_gnt", bus.ls_gnt, 1);
    chk("st_if_gnt", bus.if_gnt, 0);
    chk("st_mem_we", bus.mem_we, 4'b0011);
    chk("st_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
    chk("st_mem_addr", bus.mem_addr, 13'h100);
    next_cycle();
    ls_drive('{addr: 13'h100, we: 1'b0, be: 4'b0000, wdata: 32'h0});
    mid();
    chk("st_no_rvalid", bus.ls_rvalid, 0);
    chk("ld_ls_gnt", bus.ls_gnt, 1);
    chk("ld_mem_we", bus.mem_we, 0);
    next_cycle();
    ls_drive('{addr: 13'h100, we: 1'b1, be: 4'b0000, wdata: 32'hFFFF_FFFF});
    mid();
    chk("ld_rvalid", bus.ls_rvalid, 1);
    chk("ld_rdata", bus.ls_rdata, 32'h1122_CCDD);
    chk("be0_ls_gnt", bus.ls_gnt, 1);
    chk("be0_mem_en", bus.mem_en, 1);
    chk("be0_mem_we", bus.mem_we, 0);
    next_cycle();
    ls_drive('{addr: 13'h100, we: 1'b0, be: 4'b0000, wdata: 32'h0});
    mid();
    chk("be0_no_rvalid", bus.ls_rvalid, 0);
    next_cycle();
    bus.ls_req = 1'b0;
    mid();
    chk("be0_ld_rvalid", bus.ls_rvalid, 1);
    chk("be0_ld_rdata", bus.ls_rdata, 32'h1122_CCDD);

    // Both held: LS x4 then IF, repeating.
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 13'h010;
    bus.ls_req = 1'b1; bus.ls_addr = 13'h100;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk($sformatf("both_if_gnt%0d", k), bus.if_gnt, pat_if[k]);
      chk($sformatf("both_ls_gnt%0d", k), bus.ls_gnt, !pat_if[k]);
      if (k > 0) begin
        chk($sformatf("both_if_rv%0d", k), bus.if_rvalid, pat_if[k-1]);
        chk($sformatf("both_ls_rv%0d", k), bus.ls_rvalid, !pat_if[k-1]);
      end
      chk($sformatf("both_if_rd%0d", k), bus.if_rdata, 32'h0050_0093);
      chk($sformatf("both_ls_rd%0d", k), bus.ls_rdata, 32'h1122_CCDD);
      next_cycle();
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    mid();
    chk("both_tail_if_rv", bus.if_rvalid, 1);
    chk("both_tail_ls_rv", bus.ls_rvalid, 0);
    chk("both_tail_gnt", {bus.if_gnt, bus.ls_gnt}, 2'b00);

    // Alternating single-requester reads, one per cycle.
    next_cycle();
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        bus.if_req = alt_if[k];  bus.if_addr = alt_addr[k];
        bus.ls_req = !alt_if[k]; bus.ls_addr = alt_addr[k];
      end else begin
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
      end
      mid();
      if (k < 4) begin
        chk($sformatf("alt_if_gnt%0d", k), bus.if_gnt, alt_if[k]);
        chk($sformatf("alt_ls_gnt%0d", k), bus.ls_gnt, !alt_if[k]);
        chk($sformatf("alt_addr%0d", k), bus.mem_addr, alt_addr[k]);
      end
      if (k > 0) begin
        chk($sformatf("alt_if_rv%0d", k), bus.if_rvalid, alt_if[k-1]);
        chk($sformatf("alt_ls_rv%0d", k), bus.ls_rvalid, !alt_if[k-1]);
        chk($sformatf("alt_rd%0d", k), alt_if[k-1] ? bus.if_rdata : bus.ls_rdata, alt_data[k-1]);
      end
      next_cycle();
    end

    // Reset arriving with a load outstanding.
    bus.if_req = 1'b1; bus.if_addr = 13'h010;
    bus.ls_req = 1'b1; bus.ls_addr = 13'h101; bus.ls_we = 1'b0;
    mid();
    chk("pre_rst_ls_gnt0", bus.ls_gnt, 1);
    next_cycle();
    mid();
    chk("pre_rst_ls_gnt1", bus.ls_gnt, 1);
    #3 rst_n = 1'b0; bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_ls_rvalid", bus.ls_rvalid, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_ls_rdata", bus.ls_rdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_owner", dut.owner, OWN_NONE);
    chk("rst_streak", dut.streak, 0);
    next_cycle();
    rst_n = 1'b1;
    mid();
    chk("post_rst_ls_rvalid", bus.ls_rvalid, 0);
    chk("post_rst_if_rvalid", bus.if_rvalid, 0);

    // Streak restarted from zero: four LS grants before fetch gets in.
    next_cycle();
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk($sformatf("rst_pat_if%0d", k), bus.if_gnt, pat_if[k]);
      chk($sformatf("rst_pat_ls%0d", k), bus.ls_gnt, !pat_if[k]);
      next_cycle();
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    repeat (2) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, synchronous-read block memory between the instruction-fetch path (PC side) and the load/store path (data-memory side), so the core can run from a single unified RAM. It sits between the fetch/LSU logic and the block-memory port. Each cycle it grants at most one requester using a req/gnt handshake, and returns read data one cycle later on the owner's rvalid. Load/store has priority, bounded by a streak limit so fetch cannot starve.

## Interface
Parameters:
- ADDR_W, 13, word-address width (byte address bits [14:2])
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- MAX_LS_STREAK, 4, maximum consecutive load/store grants while a fetch is pending (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data (instruction)
- ls_req  in  1  load/store request, held until granted
- ls_we  in  1  1 = store, 0 = load
- ls_be  in  DATA_W/8  store byte enables
- ls_addr  in  ADDR_W  load/store word address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid (loads only)
- ls_rdata  out  DATA_W  load data
- mem_en  out  1  memory port enable
- mem_we  out  DATA_W/8  per-byte write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after an enabled read

## Operation
- Grant decision is combinational from the current requests and the streak counter. The mem_* outputs are driven in the same cycle as the grant.
- At most one of if_gnt/ls_gnt is high per cycle. No request gives mem_en=0, mem_we=0, and mem_addr/mem_wdata held at their previous values.
- Arbitration:
  - Only ls_req: grant LS.
  - Only if_req: grant IF.
  - Both requests: grant LS unless streak == MAX_LS_STREAK, in which case grant IF.
- Streak counter (0..MAX_LS_STREAK):
  - Increments on each LS grant while if_req=1.
  - Clears to 0 on an IF grant or whenever if_req=0.
  - Saturates at MAX_LS_STREAK; it never wraps.
- Store: mem_we = ls_be, mem_wdata = ls_wdata. A store produces no rvalid. A store with ls_be=0 is still granted and writes nothing.
- Read owner register: OWN_NONE, OWN_IF or OWN_LS, set at each granted read, else OWN_NONE. Cycle N+1 rvalid goes to the owner of the cycle-N read.
- Hold registers:
  - if_rdata and ls_rdata each capture mem_rdata when their rvalid is high.
  - Outputs show mem_rdata during rvalid and the held value afterward. Each value stays stable until that requester's next read returns.
- Back-to-back grants every cycle are allowed: full throughput of one access per cycle. The rvalid for grant N overlaps grant N+1.

## Timing
- Reset (rst=0, asynchronous) clears the following:
  - streak = 0, owner = OWN_NONE
  - if_rvalid = 0, ls_rvalid = 0
  - if_rdata = 0, ls_rdata = 0
  - mem_addr/mem_wdata registers = 0
- During reset, the grant outputs and mem_en/mem_we are forced to 0.
- Reset asserted with a read outstanding: the returning data is discarded and no rvalid is issued after release.
- Read latency: request granted in cycle N gives rvalid + data in cycle N+1. Store commits at the rising edge ending cycle N.
- A requester whose req is low in a cycle gets no gnt in that cycle. req/addr/wdata are sampled only in the granted cycle, so the requester may change them after gnt.
- Store then load to the same address in consecutive cycles: the load returns the new data, following the memory's write-first/read-after-write behaviour at the next edge.

## Structure
- Shared package unified_mem_pkg holds:
  - owner enum OWN_NONE/OWN_IF/OWN_LS
  - default ADDR_W/DATA_W constants
  - the bus struct for a request (addr, we, be, wdata)
- Single module. The streak counter and owner register are small enough to stay inline, so no sub-module is needed.

## Test plan
- Reset release, idle: all gnt/rvalid = 0, mem_en = 0, if_rdata = ls_rdata = 0.
- if_req only, addr 0x010 preloaded with 0x00500093: if_gnt in cycle N, if_rvalid with if_rdata=0x00500093 in N+1. if_rdata holds that value afterward.
- Store ls_addr 0x100, ls_be=4'b0011, wdata 0xAABBCCDD over existing 0x11223344, then load 0x100: ls_rvalid with 0x1122CCDD, and no rvalid for the store.
- Both requests held continuously, MAX_LS_STREAK=4: grant pattern LS,LS,LS,LS,IF repeating. rvalids are routed to the matching owner each following cycle.
- Alternating IF/LS reads every cycle: one grant per cycle, no bubbles, each rvalid exactly one cycle after its gnt.
- rst pulsed low in the cycle after a granted load: no ls_rvalid appears, and streak/owner return to 0/OWN_NONE.
